// File: rtl/wb_burst_pkg.sv
// Shared types for the Wishbone burst master: request/response beats,
// response status codes, CTI encodings and the engine state encoding.
package wb_burst_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int SEL_W  = DATA_W / 8;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        STS_OK      = 2'd0,
        STS_ERR     = 2'd1,
        STS_TIMEOUT = 2'd2,
        STS_ABORT   = 2'd3
    } wb_status_e;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
        logic [SEL_W-1:0]  sel;
        logic              we;
        logic              last;
        logic [1:0]        bte;
    } wb_req_s;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        wb_status_e        status;
    } wb_rsp_s;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_req_fifo.sv
// Request queue: DEPTH x W synchronous FIFO with show-ahead head.
// Ports: push/din, pop/dout (head), full, empty, count (occupancy).
module wb_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so push while full is legal then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 master: queues per-beat requests, issues classic/incrementing
// bursts with CTI/BTE, returns one response per beat (OK/ERR/TIMEOUT/ABORT).
// Ports: req_* stream in, rsp_* stream out, m_wb_* bus, busy_o.
module wb_burst_master
    import wb_burst_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  wb_req_s           req_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output wb_rsp_s           rsp_o,
    output logic [ADDR_W-1:0] m_wb_adr_o,
    output logic [DATA_W-1:0] m_wb_dat_o,
    input  logic [DATA_W-1:0] m_wb_dat_i,
    output logic [SEL_W-1:0]  m_wb_sel_o,
    output logic              m_wb_we_o,
    output logic              m_wb_cyc_o,
    output logic              m_wb_stb_o,
    input  logic              m_wb_ack_i,
    input  logic              m_wb_err_i,
    output logic [2:0]        m_wb_cti_o,
    output logic [1:0]        m_wb_bte_o,
    output logic              busy_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    wb_state_e                  state;
    wb_state_e                  state_nx;
    logic [$bits(wb_req_s)-1:0] head_bits;
    wb_req_s                    head;
    logic                       q_full;
    logic                       q_empty;
    logic [CW-1:0]              q_count;
    logic                       push;
    logic                       pop;
    logic                       rsp_free;
    logic                       strobe_ok;
    logic                       cyc;
    logic                       stb;
    logic                       rsp_load;
    wb_rsp_s                    rsp_nx;
    wb_rsp_s                    rsp_q;
    logic                       rsp_valid;
    logic                       in_burst;
    logic                       in_burst_nx;
    logic [TW-1:0]              timer;

    assign push        = req_valid_i && !q_full;
    assign req_ready_o = !q_full;
    assign head        = head_bits;

    wb_req_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(wb_req_s))
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .push  (push),
        .din   (req_i),
        .pop   (pop),
        .dout  (head_bits),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // A beat may only be strobed if its response has somewhere to go.
    assign rsp_free  = !rsp_valid || rsp_ready_i;
    assign strobe_ok = !q_empty && rsp_free;

    always_comb begin
        state_nx    = state;
        cyc         = 1'b0;
        stb         = 1'b0;
        pop         = 1'b0;
        rsp_load    = 1'b0;
        rsp_nx      = '{dat: '0, status: STS_OK};
        in_burst_nx = in_burst;
        unique case (state)
            S_IDLE: begin
                if (strobe_ok) state_nx = S_BUS;
            end
            S_BUS: begin
                cyc = 1'b1;
                stb = strobe_ok;
                if (stb && m_wb_err_i) begin
                    pop         = 1'b1;
                    rsp_load    = 1'b1;
                    rsp_nx      = '{dat: '0, status: STS_ERR};
                    in_burst_nx = 1'b0;
                    state_nx    = head.last ? S_IDLE : S_FLUSH;
                end else if (stb && m_wb_ack_i) begin
                    pop      = 1'b1;
                    rsp_load = 1'b1;
                    rsp_nx   = '{dat: m_wb_dat_i, status: STS_OK};
                    if (head.last) begin
                        in_burst_nx = 1'b0;
                        state_nx    = S_IDLE;
                    end else begin
                        in_burst_nx = 1'b1;
                        // Another queued beat: keep stb up, zero-wait.
                        state_nx    = (q_count > ONE_CNT) ? S_BUS : S_WAIT;
                    end
                end else if (stb && timer == TMO_LAST) begin
                    // This is the TIMEOUT-th strobe cycle without a reply.
                    pop         = 1'b1;
                    rsp_load    = 1'b1;
                    rsp_nx      = '{dat: '0, status: STS_TIMEOUT};
                    in_burst_nx = 1'b0;
                    state_nx    = head.last ? S_IDLE : S_FLUSH;
                end else if (!stb) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                cyc = 1'b1;
                if (strobe_ok) state_nx = S_BUS;
            end
            S_FLUSH: begin
                if (strobe_ok) begin
                    pop      = 1'b1;
                    rsp_load = 1'b1;
                    rsp_nx   = '{dat: '0, status: STS_ABORT};
                    if (head.last) state_nx = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= S_IDLE;
            in_burst <= 1'b0;
            timer    <= '0;
        end else begin
            state    <= state_nx;
            in_burst <= in_burst_nx;
            if (stb && !m_wb_ack_i && !m_wb_err_i) timer <= timer + 1'b1;
            else                                   timer <= '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else if (rsp_load) begin
            rsp_valid <= 1'b1;
            rsp_q     <= rsp_nx;
        end else if (rsp_ready_i) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid;
    assign rsp_o       = rsp_q;
    assign m_wb_cyc_o  = cyc;
    assign m_wb_stb_o  = stb;
    assign busy_o      = cyc || !q_empty;

    // Bus fields are zero whenever no beat is strobed.
    always_comb begin
        m_wb_adr_o = '0;
        m_wb_dat_o = '0;
        m_wb_sel_o = '0;
        m_wb_we_o  = 1'b0;
        m_wb_bte_o = 2'b00;
        m_wb_cti_o = CTI_CLASSIC;
        if (stb) begin
            m_wb_adr_o = head.adr;
            m_wb_dat_o = head.dat;
            m_wb_sel_o = head.sel;
            m_wb_we_o  = head.we;
            m_wb_bte_o = head.bte;
            if (!head.last)    m_wb_cti_o = CTI_INCR;
            else if (in_burst) m_wb_cti_o = CTI_EOB;
            else               m_wb_cti_o = CTI_CLASSIC;
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: single, burst, error, timeout,
// response back-pressure and reset-while-full cases.
module tb_wb_burst_master;
    import wb_burst_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    wb_req_s           req = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    wb_rsp_s           rsp;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_o;
    logic [DATA_W-1:0] dat_i;
    logic [SEL_W-1:0]  sel;
    logic              we, cyc, stb, ack, err, busy;
    logic [2:0]        cti;
    logic [1:0]        bte;

    int n_tests = 0;
    int n_fail  = 0;

    // slave model controls
    bit mute   = 1'b0;
    int wait_n = 0;
    int err_at = -1;
    int wcnt   = 0;
    int slv_beats = 0;

    // monitor logs
    int cyc_cycles = 0, stb_cycles = 0, cyc_rises = 0;
    logic cyc_prev = 1'b0;
    int b_n = 0, r_n = 0;
    logic [31:0] b_adr [64];
    logic [31:0] b_dat [64];
    logic        b_we  [64];
    logic [2:0]  b_cti [64];
    logic [1:0]  b_bte [64];
    logic [31:0] r_dat [64];
    logic [1:0]  r_sts [64];

    always #5 clk = ~clk;

    wb_burst_master #(.DEPTH(4), .TIMEOUT(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_i       (req),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_o       (rsp),
        .m_wb_adr_o  (adr),
        .m_wb_dat_o  (dat_o),
        .m_wb_dat_i  (dat_i),
        .m_wb_sel_o  (sel),
        .m_wb_we_o   (we),
        .m_wb_cyc_o  (cyc),
        .m_wb_stb_o  (stb),
        .m_wb_ack_i  (ack),
        .m_wb_err_i  (err),
        .m_wb_cti_o  (cti),
        .m_wb_bte_o  (bte),
        .busy_o      (busy)
    );

    assign dat_i = {16'hA5A5, adr[15:0]};
    assign ack = stb && !mute && (wcnt == wait_n) && (slv_beats != err_at);
    assign err = stb && !mute && (wcnt == wait_n) && (slv_beats == err_at);

    always @(posedge clk) begin
        if (stb) begin
            if (ack || err) begin
                wcnt      <= 0;
                slv_beats <= slv_beats + 1;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    always @(negedge clk) begin
        cyc_prev <= cyc;
        if (cyc) cyc_cycles <= cyc_cycles + 1;
        if (cyc && !cyc_prev) cyc_rises <= cyc_rises + 1;
        if (stb) stb_cycles <= stb_cycles + 1;
        if (stb && (ack || err) && b_n < 64) begin
            b_adr[b_n] <= adr;
            b_dat[b_n] <= dat_o;
            b_we[b_n]  <= we;
            b_cti[b_n] <= cti;
            b_bte[b_n] <= bte;
            b_n        <= b_n + 1;
        end
        if (rsp_valid && rsp_ready && r_n < 64) begin
            r_dat[r_n] <= rsp.dat;
            r_sts[r_n] <= rsp.status;
            r_n        <= r_n + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic l, input logic [1:0] b);
        int   k   = 0;
        logic acc = 1'b0;
        req.adr  = a;
        req.dat  = d;
        req.sel  = 4'hF;
        req.we   = w;
        req.last = l;
        req.bte  = b;
        req_valid = 1'b1;
        while (!acc && k < 100) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            k++;
        end
        req_valid = 1'b0;
        if (!acc) check("push_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_rsp(input string tag, input int base, input int n);
        int k = 0;
        while ((r_n - base) < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, 64'(r_n - base), 64'(n));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rb, bb, sc, cc, cr;
        logic [2:0]  exp_cti [4];
        logic [1:0]  exp_sts [5];
        exp_cti[0] = 3'b010; exp_cti[1] = 3'b010;
        exp_cti[2] = 3'b010; exp_cti[3] = 3'b111;
        exp_sts[0] = 2'd0; exp_sts[1] = 2'd1; exp_sts[2] = 2'd3;
        exp_sts[3] = 2'd3; exp_sts[4] = 2'd0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", 64'(cyc), 64'd0);
        check("rst_stb", 64'(stb), 64'd0);
        check("rst_adr", 64'(adr), 64'd0);
        check("rst_cti", 64'(cti), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp", 64'(rsp), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: single write, two wait states
        wait_n = 2;
        rb = r_n; bb = b_n; sc = stb_cycles; cc = cyc_cycles;
        push(32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 2'b00);
        wait_rsp("t1_rsp_cnt", rb, 1);
        idle(3);
        check("t1_stb_cycles", 64'(stb_cycles - sc), 64'd3);
        check("t1_cyc_cycles", 64'(cyc_cycles - cc), 64'd3);
        check("t1_adr", 64'(b_adr[bb]), 64'h100);
        check("t1_dat", 64'(b_dat[bb]), 64'hDEADBEEF);
        check("t1_we", 64'(b_we[bb]), 64'd1);
        check("t1_cti", 64'(b_cti[bb]), 64'd0);
        check("t1_status", 64'(r_sts[rb]), 64'd0);
        wait_n = 0;

        // 2: 4-beat read burst, zero-wait slave
        rb = r_n; bb = b_n; sc = stb_cycles; cc = cyc_cycles; cr = cyc_rises;
        push(32'h200, 32'h0, 1'b0, 1'b0, 2'b00);
        push(32'h204, 32'h0, 1'b0, 1'b0, 2'b00);
        push(32'h208, 32'h0, 1'b0, 1'b0, 2'b00);
        push(32'h20C, 32'h0, 1'b0, 1'b1, 2'b00);
        wait_rsp("t2_rsp_cnt", rb, 4);
        idle(3);
        check("t2_stb_cycles", 64'(stb_cycles - sc), 64'd4);
        check("t2_cyc_cycles", 64'(cyc_cycles - cc), 64'd4);
        check("t2_cyc_rises", 64'(cyc_rises - cr), 64'd1);
        check("t2_we", 64'(b_we[bb]), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("t2_cti", 64'(b_cti[bb+i]), 64'(exp_cti[i]));
            check("t2_rdata", 64'(r_dat[rb+i]), 64'(32'hA5A50200 + 32'(4*i)));
            check("t2_status", 64'(r_sts[rb+i]), 64'd0);
        end

        // 3: error on beat 2 of a burst, then a clean single read
        err_at = slv_beats + 1;
        rb = r_n; bb = b_n; cr = cyc_rises;
        push(32'h300, 32'h11, 1'b1, 1'b0, 2'b10);
        push(32'h304, 32'h22, 1'b1, 1'b0, 2'b10);
        push(32'h308, 32'h33, 1'b1, 1'b0, 2'b10);
        push(32'h30C, 32'h44, 1'b1, 1'b1, 2'b10);
        push(32'h400, 32'h0,  1'b0, 1'b1, 2'b00);
        wait_rsp("t3_rsp_cnt", rb, 5);
        idle(3);
        for (int i = 0; i < 5; i++)
            check("t3_status", 64'(r_sts[rb+i]), 64'(exp_sts[i]));
        check("t3_err_dat", 64'(r_dat[rb+1]), 64'd0);
        check("t3_abort_dat", 64'(r_dat[rb+3]), 64'd0);
        check("t3_next_rdata", 64'(r_dat[rb+4]), 64'hA5A50400);
        check("t3_bus_beats", 64'(b_n - bb), 64'd3);
        check("t3_cyc_rises", 64'(cyc_rises - cr), 64'd2);
        check("t3_bte", 64'(b_bte[bb]), 64'd2);
        check("t3_cti0", 64'(b_cti[bb]), 64'b010);
        check("t3_next_adr", 64'(b_adr[bb+2]), 64'h400);
        check("t3_next_cti", 64'(b_cti[bb+2]), 64'd0);
        err_at = -1;

        // 4: slave never answers
        mute = 1'b1;
        rb = r_n; sc = stb_cycles; cc = cyc_cycles;
        push(32'h500, 32'h0, 1'b0, 1'b1, 2'b00);
        wait_rsp("t4_rsp_cnt", rb, 1);
        idle(3);
        check("t4_stb_cycles", 64'(stb_cycles - sc), 64'd8);
        check("t4_cyc_cycles", 64'(cyc_cycles - cc), 64'd8);
        check("t4_status", 64'(r_sts[rb]), 64'd2);
        check("t4_dat", 64'(r_dat[rb]), 64'd0);
        check("t4_cyc_after", 64'(cyc), 64'd0);
        mute = 1'b0;

        // 5: response back-pressure inside a 3-beat burst
        rsp_ready = 1'b0;
        rb = r_n; bb = b_n; sc = stb_cycles; cr = cyc_rises;
        push(32'h600, 32'h0, 1'b0, 1'b0, 2'b00);
        push(32'h604, 32'h0, 1'b0, 1'b0, 2'b00);
        push(32'h608, 32'h0, 1'b0, 1'b1, 2'b00);
        idle(5);
        @(negedge clk);
        check("t5_hold_cyc", 64'(cyc), 64'd1);
        check("t5_hold_stb", 64'(stb), 64'd0);
        check("t5_hold_valid", 64'(rsp_valid), 64'd1);
        check("t5_hold_dat", 64'(rsp.dat), 64'hA5A50600);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_rsp("t5_rsp_cnt", rb, 3);
        idle(4);
        check("t5_rsp_total", 64'(r_n - rb), 64'd3);
        check("t5_bus_beats", 64'(b_n - bb), 64'd3);
        check("t5_stb_cycles", 64'(stb_cycles - sc), 64'd3);
        check("t5_cyc_rises", 64'(cyc_rises - cr), 64'd1);
        for (int i = 0; i < 3; i++)
            check("t5_rdata", 64'(r_dat[rb+i]), 64'(32'hA5A50600 + 32'(4*i)));

        // 6: fill the queue behind a stalled burst, then reset
        mute = 1'b1;
        push(32'h700, 32'h0, 1'b1, 1'b0, 2'b00);
        push(32'h704, 32'h0, 1'b1, 1'b0, 2'b00);
        push(32'h708, 32'h0, 1'b1, 1'b0, 2'b00);
        push(32'h70C, 32'h0, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        check("t6_full_ready", 64'(req_ready), 64'd0);
        check("t6_cyc_open", 64'(cyc), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_cyc", 64'(cyc), 64'd0);
        check("t6_rst_stb", 64'(stb), 64'd0);
        check("t6_rst_adr", 64'(adr), 64'd0);
        check("t6_rst_valid", 64'(rsp_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mute = 1'b0;
        sc = stb_cycles;
        idle(4);
        check("t6_post_busy", 64'(busy), 64'd0);
        check("t6_post_cyc", 64'(cyc), 64'd0);
        check("t6_post_stb", 64'(stb_cycles - sc), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
